// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and default bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // 50 MHz system clock at 115200 baud
  localparam int CLKS_PER_BIT_DEF = 434;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: reloads on clear or on expiry, pulses bit_tick on the last
// cycle of every bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign bit_tick = !clear && (r_cnt == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter draining a first-word-fall-through FIFO: start, DBIT data LSB-first,
// optional even parity (macro UART_TX_PARITY_EN), STOP_BITS stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DBIT         = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            empty,
  input  logic [DBIT-1:0] rd_data,
  output logic            rd,
  output logic            tx,
  output logic            busy,
  output logic            tx_done_tick
);

  localparam int IW = $clog2(DBIT);
  localparam logic [IW-1:0] LAST_DATA = IW'(DBIT - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  uart_state_t     r_state;
  logic [IW-1:0]   r_idx;
  logic [DBIT-1:0] r_shift;
  logic            r_tx;
  logic            r_busy;
  logic            w_bit_tick;
  logic            w_clear;
  logic            w_pop;
`ifdef UART_TX_PARITY_EN
  logic            r_par;
`endif

  // Reset gating keeps the FIFO untouched while the block is held in reset
  assign w_pop   = (r_state == ST_IDLE) && !empty && !reset;
  assign w_clear = (r_state == ST_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_clear),
    .bit_tick(w_bit_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state <= ST_START;
            r_idx   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (w_bit_tick) begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_bit_tick) begin
            if (r_idx == LAST_DATA) begin
              r_idx   <= '0;
`ifdef UART_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_tx    <= r_par;
`else
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              // r_shift shifts on this same edge, so bit 1 is the next bit on the line
              r_idx <= r_idx + 1'b1;
              r_tx  <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_tick) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_tick) begin
            if (r_idx == LAST_STOP) begin
              r_state <= ST_IDLE;
              r_idx   <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_shift <= rd_data;
    end else if ((r_state == ST_DATA) && w_bit_tick) begin
      r_shift <= r_shift >> 1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_par <= ^rd_data;
    end
  end
`endif

  assign rd           = w_pop;
  assign tx           = r_tx;
  assign busy         = r_busy;
  assign tx_done_tick = (r_state == ST_STOP) && w_bit_tick && (r_idx == LAST_STOP);

endmodule
